// File: rtl/stu_spec_store_buffer.sv
// Speculative store buffer for the Level-2 core: holds stores until the Validator
// commits (drain to memory in order) or squashes (discard); forwards to the core's loads.

package stu_pkg;
  typedef logic [39:0] addr_t;
endpackage

module stu_spec_store_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          l2_spec_task_active_in,
  input  logic                          spec_st_valid_in,
  input  stu_pkg::addr_t                spec_st_pa_in,
  input  logic [DATA_WIDTH-1:0]         spec_st_data_in,
  input  logic [DATA_WIDTH/8-1:0]       spec_st_be_in,
  output logic                          spec_st_ready_out,
  input  logic                          fwd_ld_valid_in,
  input  stu_pkg::addr_t                fwd_ld_pa_in,
  output logic                          fwd_hit_out,
  output logic [DATA_WIDTH-1:0]         fwd_data_out,
  output logic [DATA_WIDTH/8-1:0]       fwd_be_out,
  input  logic                          commit_in,
  input  logic                          squash_in,
  output logic                          mem_wr_valid_out,
  output stu_pkg::addr_t                mem_wr_pa_out,
  output logic [DATA_WIDTH-1:0]         mem_wr_data_out,
  output logic [DATA_WIDTH/8-1:0]       mem_wr_be_out,
  input  logic                          mem_wr_ready_in,
  output logic                          overflow_out,
  output logic                          drain_done_out,
  output logic [$clog2(DEPTH):0]        count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [PtrW-1:0]       r_head, r_tail;
  logic [CntW-1:0]       r_count;
  logic                  r_overflow;
  logic [DEPTH-1:0]      r_valid;
  stu_pkg::addr_t        r_pa   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [BeW-1:0]        r_be   [DEPTH];

  logic            w_full, w_ready, w_st_accept, w_wr_fire, w_clear;
  logic [PtrW-1:0] w_fwd_idx;

  assign w_full      = (r_count == CntW'(DEPTH));
  assign w_ready     = (r_state == StCollect) & l2_spec_task_active_in & ~w_full & ~r_overflow;
  assign w_st_accept = spec_st_valid_in & w_ready;
  assign w_wr_fire   = (r_state == StDrain) & mem_wr_ready_in;

  assign spec_st_ready_out = w_ready;
  assign overflow_out      = r_overflow;
  assign count_out         = r_count;

  always_comb begin
    w_state_next     = r_state;
    w_clear          = 1'b0;
    drain_done_out   = 1'b0;
    mem_wr_valid_out = 1'b0;
    mem_wr_pa_out    = '0;
    mem_wr_data_out  = '0;
    mem_wr_be_out    = '0;
    case (r_state)
      StIdle: begin
        if (l2_spec_task_active_in) w_state_next = StCollect;
      end
      StCollect: begin
        // Commit after an overflow cannot be trusted, so it discards like a squash.
        if (squash_in || (commit_in && r_overflow)) begin
          w_clear      = 1'b1;
          w_state_next = StIdle;
        end else if (commit_in) begin
          w_state_next = ((r_count != '0) || w_st_accept) ? StDrain : StDone;
        end
      end
      StDrain: begin
        mem_wr_valid_out = 1'b1;
        mem_wr_pa_out    = r_pa[r_head];
        mem_wr_data_out  = r_data[r_head];
        mem_wr_be_out    = r_be[r_head];
        if (mem_wr_ready_in && (r_count == CntW'(1))) w_state_next = StDone;
      end
      StDone: begin
        drain_done_out = 1'b1;
        w_state_next   = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_valid    <= '0;
      end else begin
        if (w_st_accept) begin
          r_valid[r_tail] <= 1'b1;
          r_tail          <= r_tail + PtrW'(1);
        end
        if (w_wr_fire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + PtrW'(1);
        end
        case ({w_st_accept, w_wr_fire})
          2'b10:   r_count <= r_count + CntW'(1);
          2'b01:   r_count <= r_count - CntW'(1);
          default: r_count <= r_count;
        endcase
        if ((r_state == StCollect) && spec_st_valid_in && w_full) r_overflow <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: every read is qualified by a valid bit or the FSM.
  always_ff @(posedge clk) begin
    if (w_st_accept) begin
      r_pa[r_tail]   <= spec_st_pa_in;
      r_data[r_tail] <= spec_st_data_in;
      r_be[r_tail]   <= spec_st_be_in;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = '0;
    fwd_be_out   = '0;
    w_fwd_idx    = '0;
    if (fwd_ld_valid_in && ((r_state == StCollect) || (r_state == StDrain))) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_fwd_idx = r_head + PtrW'(i);
        if (r_valid[w_fwd_idx] && (r_pa[w_fwd_idx] == fwd_ld_pa_in)) begin
          fwd_hit_out  = 1'b1;
          fwd_data_out = r_data[w_fwd_idx];
          fwd_be_out   = r_be[w_fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_stu_spec_store_buffer.sv
// Bench for stu_spec_store_buffer: directed test-plan steps plus a random phase, all
// checked every cycle against a queue-based model of the buffer.

module tb_stu_spec_store_buffer;

  localparam int DEPTH = 8;
  localparam int MIdle = 0, MCollect = 1, MDrain = 2, MDone = 3;

  typedef struct {
    logic [39:0] pa;
    logic [63:0] data;
    logic [7:0]  be;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           active, st_valid, ld_valid, commit, squash, mem_ready;
  stu_pkg::addr_t st_pa, ld_pa;
  logic [63:0]    st_data;
  logic [7:0]     st_be;

  logic           st_ready, fwd_hit, mem_valid, ovf, done;
  logic [63:0]    fwd_data, mem_data;
  logic [7:0]     fwd_be, mem_be;
  stu_pkg::addr_t mem_pa;
  logic [3:0]     count;

  ent_t q[$];
  bit   m_ovf;
  int   m_mode;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stu_spec_store_buffer #(.DEPTH(8), .DATA_WIDTH(64)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .l2_spec_task_active_in (active),
    .spec_st_valid_in       (st_valid),
    .spec_st_pa_in          (st_pa),
    .spec_st_data_in        (st_data),
    .spec_st_be_in          (st_be),
    .spec_st_ready_out      (st_ready),
    .fwd_ld_valid_in        (ld_valid),
    .fwd_ld_pa_in           (ld_pa),
    .fwd_hit_out            (fwd_hit),
    .fwd_data_out           (fwd_data),
    .fwd_be_out             (fwd_be),
    .commit_in              (commit),
    .squash_in              (squash),
    .mem_wr_valid_out       (mem_valid),
    .mem_wr_pa_out          (mem_pa),
    .mem_wr_data_out        (mem_data),
    .mem_wr_be_out          (mem_be),
    .mem_wr_ready_in        (mem_ready),
    .overflow_out           (ovf),
    .drain_done_out         (done),
    .count_out              (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(st_ready), 64'd0);
    chk({tag, "_hit"}, 64'(fwd_hit), 64'd0);
    chk({tag, "_fdata"}, fwd_data, 64'd0);
    chk({tag, "_fbe"}, 64'(fwd_be), 64'd0);
    chk({tag, "_mvalid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_mpa"}, 64'(mem_pa), 64'd0);
    chk({tag, "_mdata"}, mem_data, 64'd0);
    chk({tag, "_mbe"}, 64'(mem_be), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
  endtask

  task automatic clear_inputs();
    active = 0; st_valid = 0; st_pa = '0; st_data = '0; st_be = '0;
    ld_valid = 0; ld_pa = '0; commit = 0; squash = 0; mem_ready = 1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_mode = MIdle;
  endtask

  task automatic check_outputs();
    bit   exp_ready, exp_hit;
    ent_t hit_e;
    exp_ready = (m_mode == MCollect) && active && (q.size() < DEPTH) && !m_ovf;
    exp_hit   = 0;
    hit_e     = '{pa: '0, data: '0, be: '0};
    if (ld_valid && (m_mode == MCollect || m_mode == MDrain))
      foreach (q[i]) if (q[i].pa == ld_pa) begin exp_hit = 1; hit_e = q[i]; end
    chk("ready", 64'(st_ready), 64'(exp_ready));
    chk("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
    if (exp_hit) begin
      chk("fwd_data", fwd_data, hit_e.data);
      chk("fwd_be", 64'(fwd_be), 64'(hit_e.be));
    end
    chk("mem_valid", 64'(mem_valid), 64'(m_mode == MDrain));
    if (m_mode == MDrain) begin
      chk("mem_pa", 64'(mem_pa), 64'(q[0].pa));
      chk("mem_data", mem_data, q[0].data);
      chk("mem_be", 64'(mem_be), 64'(q[0].be));
    end
    chk("drain_done", 64'(done), 64'(m_mode == MDone));
    chk("count", 64'(count), 64'(q.size()));
    chk("overflow", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic model_update();
    bit full, acc;
    full = (q.size() == DEPTH);
    acc  = st_valid && (m_mode == MCollect) && active && !full && !m_ovf;
    case (m_mode)
      MIdle: if (active) m_mode = MCollect;
      MCollect: begin
        if (squash || (commit && m_ovf)) begin
          q.delete();
          m_ovf  = 0;
          m_mode = MIdle;
        end else begin
          if (acc) q.push_back('{pa: st_pa, data: st_data, be: st_be});
          if (st_valid && full) m_ovf = 1;
          if (commit) m_mode = (q.size() > 0) ? MDrain : MDone;
        end
      end
      MDrain: if (mem_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_mode = MDone;
      end
      default: m_mode = MIdle;
    endcase
  endtask

  // Check at the falling edge, update the model at the rising edge, return 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic store(input logic [39:0] pa, input logic [63:0] data, input logic [7:0] be);
    st_valid = 1; st_pa = pa; st_data = data; st_be = be;
    cycle();
    st_valid = 0;
  endtask

  task automatic drain_all(input string tag);
    commit = 1;
    cycle();
    commit = 0;
    for (int k = 0; k < 20 && m_mode != MIdle; k++) cycle();
    chk({tag, "_empty"}, 64'(count), 64'd0);
    cycle();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    model_reset();
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1;

    // In-order drain of three stores.
    active = 1;
    cycle();
    store(40'h100, 64'hA, 8'hFF);
    store(40'h108, 64'hB, 8'hFF);
    store(40'h110, 64'hC, 8'hFF);
    chk("t1_count3", 64'(count), 64'd3);
    commit = 1;
    cycle();
    commit = 0;
    chk("t1_wr0", 64'(mem_pa), 64'h100);
    cycle();
    chk("t1_wr1", 64'(mem_pa), 64'h108);
    cycle();
    chk("t1_wr2", 64'(mem_pa), 64'h110);
    cycle();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_count0", 64'(count), 64'd0);
    cycle();
    cycle();

    // Forwarding: youngest match wins, other PA misses, same-cycle store unseen.
    store(40'h200, 64'h11, 8'h0F);
    store(40'h200, 64'h22, 8'($urandom));
    ld_valid = 1; ld_pa = 40'h200;
    #1;
    chk("t2_hit", 64'(fwd_hit), 64'd1);
    chk("t2_data", fwd_data, 64'h22);
    cycle();
    ld_pa = 40'h208;
    #1;
    chk("t2_miss", 64'(fwd_hit), 64'd0);
    cycle();
    ld_pa = 40'h300;
    st_valid = 1; st_pa = 40'h300; st_data = 64'($urandom); st_be = 8'hFF;
    #1;
    chk("t2_same_cycle", 64'(fwd_hit), 64'd0);
    cycle();
    st_valid = 0;
    #1;
    chk("t2_after_store", 64'(fwd_hit), 64'd1);
    ld_valid = 0;
    squash = 1;
    cycle();
    squash = 0;
    cycle();

    // Fill, overflow, commit discards.
    for (int i = 0; i < DEPTH; i++) store(40'h1000 + 40'(8 * i), {$urandom, $urandom}, 8'($urandom));
    chk("t3_full", 64'(count), 64'd8);
    st_valid = 1; st_pa = 40'h2000; st_data = 64'h99;
    #1;
    chk("t3_ready0", 64'(st_ready), 64'd0);
    cycle();
    st_valid = 0;
    chk("t3_ovf", 64'(ovf), 64'd1);
    commit = 1;
    cycle();
    commit = 0;
    chk("t3_count0", 64'(count), 64'd0);
    chk("t3_nowrite", 64'(mem_valid), 64'd0);
    chk("t3_nodone", 64'(done), 64'd0);
    chk("t3_idle_ready", 64'(st_ready), 64'd0);
    chk("t3_ovf_clr", 64'(ovf), 64'd0);
    cycle();

    // Back-pressure with an ignored squash in DRAIN.
    store(40'h100, {$urandom, $urandom}, 8'hFF);
    store(40'h108, {$urandom, $urandom}, 8'h3C);
    mem_ready = 0;
    commit = 1;
    cycle();
    commit = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold", 64'(mem_pa), 64'h100);
      squash = (k == 1);
      cycle();
      squash = 0;
    end
    mem_ready = 1;
    cycle();
    chk("t4_second", 64'(mem_pa), 64'h108);
    cycle();
    chk("t4_done", 64'(done), 64'd1);
    cycle();
    chk("t4_done_once", 64'(done), 64'd0);
    cycle();

    // Squash and commit together: squash wins.
    for (int i = 0; i < 4; i++) store(40'h500 + 40'(8 * i), {$urandom, $urandom}, 8'($urandom));
    squash = 1; commit = 1;
    cycle();
    squash = 0; commit = 0;
    chk("t5_empty", 64'(count), 64'd0);
    chk("t5_nowrite", 64'(mem_valid), 64'd0);
    cycle();

    // Pointer wrap: 6 + 6 stores through an 8-deep buffer, with random loads.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        ld_valid = 1'($urandom);
        ld_pa = 40'h4000 + 40'(8 * $urandom_range(0, 3));
        store(40'h4000 + 40'(8 * $urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom));
      end
      ld_valid = 0;
      drain_all("t5_wrap");
    end

    // Asynchronous reset mid-drain, then empty commit.
    for (int i = 0; i < 3; i++) store(40'h600 + 40'(8 * i), {$urandom, $urandom}, 8'hFF);
    commit = 1;
    cycle();
    commit = 0;
    cycle();
    chk("t6_draining", 64'(mem_valid), 64'd1);
    rst = 0;
    #1;
    chk("t6_abort", 64'(mem_valid), 64'd0);
    chk_zero("t6_rst");
    clear_inputs();
    model_reset();
    @(posedge clk);
    #2;
    rst = 1;
    active = 1;
    cycle();
    commit = 1;
    cycle();
    commit = 0;
    chk("t6_empty_done", 64'(done), 64'd1);
    cycle();

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      active    = ($urandom_range(0, 7) != 0);
      st_valid  = 1'($urandom);
      st_pa     = 40'h8000 + 40'(8 * $urandom_range(0, 5));
      st_data   = {$urandom, $urandom};
      st_be     = 8'($urandom);
      ld_valid  = 1'($urandom);
      ld_pa     = 40'h8000 + 40'(8 * $urandom_range(0, 5));
      commit    = ($urandom_range(0, 15) == 0);
      squash    = ($urandom_range(0, 31) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stu_spec_store_buffer.md
# stu_spec_store_buffer

Write-side counterpart of the STU read-set conflict tracker. It holds the stores of the Level-2 (optimistic) speculative core so they never reach memory before validation. Buffered data is forwarded to that core's own later loads. On commit, the buffer drains its entries in program order to the memory write port. On squash, it discards them. It sits between the speculative core's post-MMU store path (physical addresses) and the shared memory write interface, and is controlled by the Forker and the Validator.

## Interface
- DEPTH, 8, number of store entries; power of two, ≥2
- DATA_WIDTH, 64, store data width in bits; BE width = DATA_WIDTH/8
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- l2_spec_task_active_in  in  1  Level-2 task active (from Forker)
- spec_st_valid_in  in  1  speculative core presents a store
- spec_st_pa_in  in  stu_pkg::addr_t  store physical address
- spec_st_data_in  in  DATA_WIDTH  store data
- spec_st_be_in  in  DATA_WIDTH/8  store byte enables
- spec_st_ready_out  out  1  store accepted when valid & ready
- fwd_ld_valid_in  in  1  speculative core load lookup
- fwd_ld_pa_in  in  stu_pkg::addr_t  load physical address
- fwd_hit_out  out  1  buffered store matches load PA
- fwd_data_out  out  DATA_WIDTH  data of youngest matching entry
- fwd_be_out  out  DATA_WIDTH/8  byte enables of that entry
- commit_in  in  1  Validator commit pulse for the speculative core
- squash_in  in  1  Validator squash pulse for the speculative core
- mem_wr_valid_out  out  1  drain write request
- mem_wr_pa_out  out  stu_pkg::addr_t  drain address
- mem_wr_data_out  out  DATA_WIDTH  drain data
- mem_wr_be_out  out  DATA_WIDTH/8  drain byte enables
- mem_wr_ready_in  in  1  memory accepts write
- overflow_out  out  1  sticky: store presented while buffer full
- drain_done_out  out  1  one-cycle pulse: commit fully retired
- count_out  out  $clog2(DEPTH)+1  occupied entries

## Operation
- The buffer is a circular FIFO with head (oldest) and tail pointers of $clog2(DEPTH) bits each, which wrap naturally, plus count. Entry storage is PA, data, BE and a valid bit.
- FSM states are IDLE, COLLECT, DRAIN and DONE.
- **IDLE:** buffer is empty and ready is 0. Moves to COLLECT when l2_spec_task_active_in=1.
- **COLLECT:**
  - spec_st_ready_out = active & (count<DEPTH) & !overflow_out.
  - An accepted store is written at tail; tail and count increment.
  - spec_st_valid_in=1 while count==DEPTH sets overflow_out.
  - If active drops without commit or squash, entries are held and ready is 0.
- **COLLECT exits (priority order):**
  - squash_in: clear all valid bits, head, tail, count and overflow; go to IDLE.
  - commit_in with overflow_out=1: treated as squash.
  - commit_in with count>0: go to DRAIN.
  - commit_in with count==0: go to DONE.
  - squash_in has priority over commit_in in the same cycle.
- **DRAIN:**
  - mem_wr_valid_out=1 and the payload is the head entry.
  - The payload is held stable until mem_wr_ready_in=1; on that handshake, head increments and count decrements.
  - The handshake on the last entry (count==1) moves the FSM to DONE.
  - squash_in and commit_in are ignored, because commit is irreversible. Stores are not accepted (ready=0).
- **DONE:** drain_done_out=1 for exactly one cycle, then the FSM goes to IDLE.
- **Forwarding:**
  - Combinational and valid in COLLECT and DRAIN only; fwd_hit_out=0 in IDLE and DONE, or when fwd_ld_valid_in=0.
  - The full-PA compare runs against all valid entries; the youngest match (closest to tail) wins.
  - No byte merging: the requester combines using fwd_be_out.
  - Entries already drained (valid cleared on handshake) do not forward.

## Timing
- Reset (rst=0): state IDLE; pointers, count and all valid bits are 0. All outputs are 0: spec_st_ready_out, fwd_hit_out, fwd_data_out, fwd_be_out, mem_wr_*_out, overflow_out, drain_done_out, count_out.
- A store accepted at edge N is visible to forwarding and count_out after edge N.
- A load in the same cycle as a store to the same PA does not see that store.
- Drain throughput is 1 entry/cycle with mem_wr_ready_in held high. The first mem_wr_valid_out is asserted the cycle after commit_in is sampled.
- With N entries and ready always 1, drain_done_out is asserted N+1 cycles after the commit edge.
- commit_in with an empty buffer: drain_done_out is asserted the cycle after commit_in.
- overflow_out is set on the edge following the refused store and stays set until squash, or until commit treated as squash.
- Asynchronous reset mid-DRAIN aborts immediately. Outputs return to 0 without waiting for a handshake.

## Test plan
- Reset, then 3 stores (PA 0x100/0x108/0x110, data 0xA/0xB/0xC, BE 0xFF), then commit with ready=1 -> writes in order 0x100, 0x108, 0x110 on consecutive cycles; drain_done pulses 4 cycles after commit; count 3->0.
- Stores to 0x200 with data 0x11 then 0x22, then a load of 0x200 -> fwd_hit=1, fwd_data=0x22; load of 0x208 -> fwd_hit=0.
- Fill to DEPTH=8, then present a 9th store -> ready=0, overflow_out=1 next cycle; commit -> no mem writes, count=0, no drain_done, FSM in IDLE.
- 2 stores, then commit with mem_wr_ready_in low for 3 cycles -> payload 0x100 held stable; squash in DRAIN ignored; both entries written; drain_done pulses once.
- 4 stores, then squash_in and commit_in in the same cycle -> buffer empty, no mem_wr_valid; pointer wrap verified by a 12-store/commit sequence through DEPTH=8.
- rst=0 asserted mid-DRAIN -> mem_wr_valid_out=0 immediately; count_out=0; next commit with an empty buffer -> drain_done the following cycle.
